// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 host transmitter types and keyboard command bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Parity bit that makes the count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : 2-FF synchronizers for the PS/2 lines, ps2_clk glitch filter
//               and falling-edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_filt,
    output logic dat_sync,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       r_clk_ff;
    logic [1:0]       r_dat_ff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;
    logic             r_fall;

    logic w_clk_s;
    logic w_differs;
    logic w_accept;

    assign w_clk_s   = r_clk_ff[1];
    assign w_differs = (w_clk_s != r_filt);
    // A new level is taken only after FILTER_LEN consecutive differing samples.
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_ff <= 2'b11;
            r_dat_ff <= 2'b11;
            r_cnt    <= '0;
            r_filt   <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_clk_ff <= {r_clk_ff[0], ps2_clk};
            r_dat_ff <= {r_dat_ff[0], ps2_dat};
            r_fall   <= w_accept && !w_clk_s;
            if (w_accept) begin
                r_filt <= w_clk_s;
                r_cnt  <= '0;
            end else if (w_differs) begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt  <= '0;
            end
        end
    end

    assign clk_filt = r_filt;
    assign dat_sync = r_dat_ff[1];
    assign fall     = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (request-to-send,
//               start, 8 data, odd parity, stop, device ACK) with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    logic w_clk_filt;
    logic w_dat_sync;
    logic w_fall;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .clk_filt (w_clk_filt),
        .dat_sync (w_dat_sync),
        .fall     (w_fall)
    );

    ps2_tx_state_e    r_state,   w_state_nxt;
    logic [9:0]       r_shift,   w_shift_nxt;
    logic [3:0]       r_bit_idx, w_bit_idx_nxt;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
    logic [TO_W-1:0]  r_to_cnt,  w_to_cnt_nxt;
    logic             r_clk_oe,  w_clk_oe_nxt;
    logic             r_dat_oe,  w_dat_oe_nxt;
    logic             r_done,    w_done_nxt;
    logic             r_err,     w_err_nxt;

    logic            w_timed;
    logic [TO_W-1:0] w_to_inc;
    logic            w_timeout;

    assign w_timed   = (r_state == REQ) || (r_state == DATA) ||
                       (r_state == ACK) || (r_state == WAIT_IDLE);
    assign w_to_inc  = r_to_cnt + TO_W'(1);
    assign w_timeout = w_timed && (w_to_inc == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_inh_cnt <= w_inh_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_dat_oe  <= w_dat_oe_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_inh_cnt_nxt = r_inh_cnt;
        w_to_cnt_nxt  = w_timed ? w_to_inc : r_to_cnt;
        w_clk_oe_nxt  = r_clk_oe;
        w_dat_oe_nxt  = r_dat_oe;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                // The cycle carrying done/err is already IDLE but must not start a frame.
                if (send && !r_done && !r_err) begin
                    w_state_nxt   = INHIBIT;
                    w_shift_nxt   = {1'b1, odd_parity(data), data};
                    w_bit_idx_nxt = '0;
                    w_inh_cnt_nxt = '0;
                    w_to_cnt_nxt  = '0;
                    w_clk_oe_nxt  = 1'b1;
                end
            end
            INHIBIT: begin
                w_clk_oe_nxt = 1'b1;
                if (r_inh_cnt != INH_MAX) begin
                    w_inh_cnt_nxt = r_inh_cnt + INH_W'(1);
                end
                if (r_inh_cnt == INH_LAST) begin
                    w_dat_oe_nxt  = 1'b1;
                    w_state_nxt   = REQ;
                    w_bit_idx_nxt = '0;
                    w_to_cnt_nxt  = '0;
                end
            end
            REQ, DATA: begin
                w_clk_oe_nxt = 1'b0;
                if (w_fall) begin
                    w_dat_oe_nxt  = ~r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[9:1]};
                    w_bit_idx_nxt = r_bit_idx + 4'd1;
                    w_state_nxt   = (r_bit_idx == 4'd9) ? ACK : DATA;
                end
            end
            ACK: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (w_fall) begin
                    w_bit_idx_nxt = r_bit_idx + 4'd1;
                    if (!w_dat_sync) begin
                        w_state_nxt = WAIT_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (w_clk_filt && w_dat_sync) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
            end
        endcase

        // Timeout wins over any completion in the same cycle.
        if (w_timeout) begin
            w_state_nxt  = IDLE;
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_done_nxt   = 1'b0;
            w_err_nxt    = 1'b1;
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed bench for ps2_host_tx with an open-drain bus and a
//               behavioural PS/2 device.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 50;
    localparam int TO   = 2000;
    localparam int FLT  = 4;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;
    logic       bus_clk, bus_dat;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0, err_cnt = 0, pulse_bad = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    assign bus_clk = ~(ps2_clk_oe | dev_clk_low);
    assign bus_dat = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (bus_clk),
        .ps2_dat    (bus_dat),
        .data       (data),
        .send       (send),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Pulse monitor: counts done/err and flags stretched or overlapping pulses.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if ((done && prev_done) || (err && prev_err) || (done && err)) pulse_bad++;
        prev_done = done;
        prev_err  = err;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        data = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Device side: measure inhibit, clock the frame out, optionally ACK.
    task automatic device_receive(input logic ack, input int stop_after,
                                  output int n_inh, output logic [10:0] bits,
                                  output logic ok);
        int n;
        ok = 1'b0;
        bits = '0;
        n_inh = 0;
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        while (ps2_clk_oe && n_inh < INH + 100) begin @(negedge clk); n_inh++; end
        if (ps2_clk_oe || !ps2_dat_oe) return;
        repeat (HALF) @(negedge clk);
        bits[0] = bus_dat;
        for (int i = 1; i <= 11; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            @(negedge clk);
            if (i <= 10) bits[i] = bus_dat;
            if (i == 10 && ack) dev_dat_low = 1'b1;
            repeat (HALF - 1) @(negedge clk);
            if (i == stop_after) begin
                ok = 1'b1;
                return;
            end
        end
        dev_dat_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic par, input logic ack,
                             input string tag);
        int d0, e0, n_inh;
        logic [10:0] bits;
        logic ok;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(d);
        device_receive(ack, 0, n_inh, bits, ok);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_bfm_ok"}, 32'(ok), 1);
        chk({tag, "_inhibit_len"}, 32'(n_inh >= INH && n_inh <= INH + 2), 1);
        chk({tag, "_frame"}, 32'(bits), 32'({1'b1, par, d, 1'b0}));
        chk({tag, "_odd_parity"}, 32'(^bits[9:1]), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_clk_oe"}, 32'(ps2_clk_oe), 0);
        chk({tag, "_dat_oe"}, 32'(ps2_dat_oe), 0);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), ack ? 1 : 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt - e0), ack ? 0 : 1);
    endtask

    initial begin
        int d0, e0, n, n_inh;
        logic [10:0] bits;
        logic ok;

        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_dat_oe", 32'(ps2_dat_oe), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_done",   32'(done), 0);
        chk("rst_err",    32'(err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED: six ones -> parity 1
        run_frame(PS2_CMD_SET_LED, 1'b1, 1'b1, "ed");
        run_frame(8'h01, 1'b0, 1'b1, "x01");
        run_frame(PS2_CMD_RESET, 1'b1, 1'b1, "xff");
        run_frame(8'h00, 1'b1, 1'b1, "x00");
        run_frame(PS2_CMD_SET_LED, 1'b1, 1'b0, "noack");

        // Device never clocks: timeout counted from the first REQ cycle.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(PS2_CMD_ECHO);
        for (int i = 0; i < INH + 20 && !ps2_dat_oe; i++) @(negedge clk);
        chk("to_req_seen", 32'(ps2_dat_oe), 1);
        n = 0;
        while (!err && n < TO + 50) begin @(negedge clk); n++; end
        chk("to_cycles", 32'(n), 32'(TO));
        chk("to_dat_oe", 32'(ps2_dat_oe), 0);
        chk("to_clk_oe", 32'(ps2_clk_oe), 0);
        chk("to_busy",   32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("to_err_cnt",  32'(err_cnt - e0), 1);
        chk("to_done_cnt", 32'(done_cnt - d0), 0);

        // send of 0x55 during the frame and in the done cycle must be ignored.
        d0 = done_cnt;
        send_byte(PS2_CMD_SET_LED);
        fork
            device_receive(1'b1, 0, n_inh, bits, ok);
            begin
                repeat (150) @(negedge clk);
                data = 8'h55; send = 1'b1;
                @(negedge clk);
                send = 1'b0;
                repeat (100) @(negedge clk);
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        chk("busy_send_frame", 32'(bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        chk("busy_send_done_seen", 32'(done), 1);
        data = 8'h55;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        chk("done_cycle_send_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        chk("done_cycle_send_idle",   32'(busy), 0);
        chk("done_cycle_send_clk_oe", 32'(ps2_clk_oe), 0);
        chk("done_cycle_send_cnt",    32'(done_cnt - d0), 1);

        // Reset after fall 5: d4 of 0xED is 0, so data is being pulled low.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(PS2_CMD_SET_LED);
        device_receive(1'b1, 5, n_inh, bits, ok);
        chk("midrst_pre_dat_oe", 32'(ps2_dat_oe), 1);
        chk("midrst_pre_busy",   32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("midrst_dat_oe", 32'(ps2_dat_oe), 0);
        chk("midrst_busy",   32'(busy), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        chk("midrst_no_err",  32'(err_cnt - e0), 0);
        run_frame(PS2_CMD_RESET, 1'b1, 1'b1, "ff_after_rst");

        chk("pulse_width", 32'(pulse_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the companion of the existing keyboard receiver and shares the same ps2_clk/ps2_dat lines.
- It sends one command byte to the keyboard: LED set 0xED, the LED mask, reset 0xFF, and so on.
- It implements the full request-to-send protocol with inhibit, start, 8 data bits, odd parity, stop and device ACK.
- Lines are driven open-drain via active-high output enables. The top level ties each line to 1'b0 when the enable is 1 and to 'z' otherwise.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles ps2_clk is held low before start (120 us @ 50 MHz; must be ≥100 us).
- TIMEOUT_CYCLES, 750000: max clk cycles from clock release to ACK completion (15 ms @ 50 MHz).
- FILTER_LEN, 4: consecutive equal synchronized samples required to accept a ps2_clk level change (glitch filter).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- ps2_clk, input, 1: PS/2 clock line as seen at the pin (asynchronous).
- ps2_dat, input, 1: PS/2 data line as seen at the pin (asynchronous).
- data, input, 8: byte to transmit, sampled when send=1 and busy=0.
- send, input, 1: single-cycle request.
- ps2_clk_oe, output, 1: 1 = pull ps2_clk low.
- ps2_dat_oe, output, 1: 1 = pull ps2_dat low.
- busy, output, 1: transfer in progress. Top level gates the receiver's rdy with it.
- done, output, 1: 1-cycle pulse, byte accepted with ACK=0.
- err, output, 1: 1-cycle pulse, missing ACK or timeout.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, err=0, state=IDLE, all counters 0.
- Reset mid-frame: both lines are released on the next edge; no done or err pulse is produced.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
  - The clock is filtered by FILTER_LEN.
  - A falling edge (fall) is a 1-cycle strobe when the filtered clock goes 1→0.
- Shift register holds {stop=1, parity, data[7:0]}, loaded at accept.
  - Parity = ~^data, so the total number of ones over data and parity is odd.
- IDLE:
  - busy=0, both oe=0.
  - send=1 → latch data, clear counters, go to INHIBIT; busy=1 from the next cycle.
- INHIBIT:
  - ps2_clk_oe=1.
  - After INHIBIT_CYCLES cycles set ps2_dat_oe=1 (start bit 0) and go to REQ.
- REQ:
  - ps2_clk_oe=0 (clock released), ps2_dat_oe stays 1.
  - Bit index=0; the timeout counter starts.
- REQ/DATA, on each fall:
  - ps2_dat_oe = ~shift[0]; shift right; index++.
  - Falls 1–8 drive d0..d7, fall 9 drives parity, fall 10 drives stop (oe=0, line released).
  - After fall 10 go to ACK.
- ACK:
  - On fall 11, sample synchronized ps2_dat.
  - 0 → WAIT_IDLE; 1 → err pulse, then IDLE.
- WAIT_IDLE:
  - Wait until the filtered clock and synchronized data are both 1, then done pulse and IDLE.
- Timeout:
  - Applies in REQ, DATA, ACK and WAIT_IDLE.
  - When the counter reaches TIMEOUT_CYCLES: release both lines, err pulse, go to IDLE.
- done and err are mutually exclusive and each lasts exactly 1 cycle.
  - busy falls in the same cycle as the pulse.
- send while busy=1 is ignored, with no queueing.
  - send in the same cycle as done/err is also ignored; a new send is accepted only from IDLE.
- Falling edges during INHIBIT are ignored, since the device must not clock while the line is inhibited.
- Counters:
  - Inhibit counter is clog2(INHIBIT_CYCLES+1) bits and saturates.
  - Timeout counter is clog2(TIMEOUT_CYCLES+1) bits.
  - Bit index is 4 bits and never exceeds 11.

Decomposition:
- Package ps2_pkg:
  - State encoding: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE.
  - Command constants: PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ECHO=8'hEE, PS2_ACK_BYTE=8'hFA.
- Sub-module ps2_line_sync:
  - 2-FF synchronizer, FILTER_LEN glitch filter and fall strobe.
  - Reused by the keyboard receiver refactor.

Test Plan:
- Device BFM clocks 10 kHz and ACKs. send with data=8'hED → clk held low ≥6000 cycles; bits sampled on device rising edges read 0,1,0,1,1,0,1,1,1 then parity 1, stop 1; device ACK → done=1 once, busy=0, both oe=0.
- data=8'h01 → parity bit 0; data=8'hFF → parity 1; data=8'h00 → parity 1. BFM checks odd parity every time.
- BFM omits ACK (ps2_dat stays high on fall 11) → err=1 for 1 cycle, done never asserted, lines released.
- BFM never clocks after request → err after exactly TIMEOUT_CYCLES cycles in REQ; ps2_dat_oe=0 on the next cycle.
- send pulses during transfer with data=8'h55 → ignored; the frame completes with 8'hED. send in the done cycle → ignored, stays IDLE.
- rst asserted after fall 5 → next cycle ps2_clk_oe=0, ps2_dat_oe=0, busy=0, no done/err. A subsequent send of 8'hFF completes correctly.
